// File: rtl/result_monitor.sv
// result_monitor
//   Receiving end of the stimulus path. Rebuilds the expected DUT result from the
//   delayed operands, aligns it to the DUT output through a delay line tapped at
//   L = D - OPND_LAT, and compares the two every cycle once aligned. Counts the
//   compared vectors and the mismatches, and flags an unsupported measured delay.
//   Optional feature macro: MON_CAPTURE_EN (first-mismatch capture registers/ports).
// Ports
//   clk_dut, reset         clock (posedge) and async active-high reset
//   i_dut_delay            measured DUT delay D, all-ones = not yet measured
//   i_drive_delayed_a/b    operands, OPND_LAT cycles after drive
//   i_zero_inject          driver forced zero operands in this (delayed) cycle
//   i_dut_out              DUT result
//   i_clear                sync clear of counters, error flag and capture
//   o_state                one-hot FSM state (IDLE/FILL/CHECK/LATERR)
//   o_test_count/err_count saturating counters
//   o_error, o_lat_err     sticky mismatch flag, delay-out-of-range flag
//   o_fail_*               (MON_CAPTURE_EN) first mismatch operands/results
module result_monitor #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned OP       = 0,
    parameter int unsigned MAX_LAT  = 15,
    parameter int unsigned OPND_LAT = 2,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk_dut,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_dut_delay,
    input  logic [WIDTH-1:0] i_drive_delayed_a,
    input  logic [WIDTH-1:0] i_drive_delayed_b,
    input  logic             i_zero_inject,
    input  logic [WIDTH-1:0] i_dut_out,
    input  logic             i_clear,
    output logic [3:0]       o_state,
    output logic [CNT_W-1:0] o_test_count,
    output logic [CNT_W-1:0] o_err_count,
    output logic             o_error,
    output logic             o_lat_err
`ifdef MON_CAPTURE_EN
    ,
    output logic [WIDTH-1:0] o_fail_a,
    output logic [WIDTH-1:0] o_fail_b,
    output logic [WIDTH-1:0] o_fail_got,
    output logic [WIDTH-1:0] o_fail_exp,
    output logic             o_fail_valid
`endif
);

    localparam int unsigned TAP_W = (MAX_LAT < 2) ? 1 : $clog2(MAX_LAT + 1);

    typedef enum logic [3:0] {
        S_IDLE   = 4'b0001,
        S_FILL   = 4'b0010,
        S_CHECK  = 4'b0100,
        S_LATERR = 4'b1000
    } state_t;

    state_t                         state, state_nxt;
    logic [WIDTH-1:0]               tap0;
    logic [MAX_LAT:1][WIDTH-1:0]    exp_line;
    logic [MAX_LAT:1]               mask_line;
    logic [WIDTH-1:0]               exp_tap;
    logic                           mask_tap;
    logic [TAP_W-1:0]               tap_l;
    logic [TAP_W-1:0]               fill_cnt;
    logic [TAP_W-1:0]               l_meas;
    logic                           d_valid;
    logic                           d_bad;
    logic                           cmp_en_c;
    logic                           mismatch_c;

    // Reference function on the delayed operands (tap 0)
    always_comb begin
        if (OP == 0)      tap0 = i_drive_delayed_a + i_drive_delayed_b;
        else if (OP == 1) tap0 = i_drive_delayed_a - i_drive_delayed_b;
        else              tap0 = i_drive_delayed_a * i_drive_delayed_b;
    end

    // Expected-value and zero-inject mask delay lines, kept strictly parallel
    always_ff @(posedge clk_dut or posedge reset) begin
        if (reset) begin
            exp_line  <= '0;
            mask_line <= '0;
        end else begin
            exp_line[1]  <= tap0;
            mask_line[1] <= i_zero_inject;
            for (int unsigned k = 2; k <= MAX_LAT; k++) begin
                exp_line[k]  <= exp_line[k-1];
                mask_line[k] <= mask_line[k-1];
            end
        end
    end

    // Tap L selection; L = 0 uses the combinational tap
    always_comb begin
        exp_tap  = tap0;
        mask_tap = i_zero_inject;
        if (tap_l != '0) begin
            exp_tap  = exp_line[tap_l];
            mask_tap = mask_line[tap_l];
        end
    end

    // Measured delay qualification
    assign d_valid = (i_dut_delay != '1);
    assign d_bad   = (i_dut_delay < WIDTH'(OPND_LAT)) ||
                     (i_dut_delay > WIDTH'(OPND_LAT + MAX_LAT));
    assign l_meas  = TAP_W'(i_dut_delay - WIDTH'(OPND_LAT));

    // State register
    always_ff @(posedge clk_dut or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state and compare enable
    always_comb begin
        state_nxt = state;
        cmp_en_c  = 1'b0;
        case (state)
            S_IDLE:   if (d_valid) state_nxt = d_bad ? S_LATERR : S_FILL;
            S_FILL:   if (fill_cnt == tap_l) state_nxt = S_CHECK;
            S_CHECK:  cmp_en_c = !mask_tap;
            S_LATERR: state_nxt = S_LATERR;
            default:  state_nxt = S_IDLE;
        endcase
    end

    assign mismatch_c = cmp_en_c && (i_dut_out != exp_tap);

    // Tap index tracks the measurement while idle, frozen afterwards; FILL counts L+1 cycles
    always_ff @(posedge clk_dut or posedge reset) begin
        if (reset) begin
            tap_l    <= '0;
            fill_cnt <= '0;
        end else if (state == S_IDLE) begin
            tap_l    <= l_meas;
            fill_cnt <= '0;
        end else if (state == S_FILL) begin
            fill_cnt <= fill_cnt + TAP_W'(1);
        end
    end

    // Saturating counters and sticky flags; clear has priority over a compare
    always_ff @(posedge clk_dut or posedge reset) begin
        if (reset) begin
            o_test_count <= '0;
            o_err_count  <= '0;
            o_error      <= 1'b0;
            o_lat_err    <= 1'b0;
        end else begin
            o_lat_err <= (state_nxt == S_LATERR);
            if (i_clear) begin
                o_test_count <= '0;
                o_err_count  <= '0;
                o_error      <= 1'b0;
            end else if (cmp_en_c) begin
                if (o_test_count != '1) o_test_count <= o_test_count + CNT_W'(1);
                if (mismatch_c) begin
                    if (o_err_count != '1) o_err_count <= o_err_count + CNT_W'(1);
                    o_error <= 1'b1;
                end
            end
        end
    end

    assign o_state = state;

`ifdef MON_CAPTURE_EN
    logic [MAX_LAT:1][WIDTH-1:0] a_line;
    logic [MAX_LAT:1][WIDTH-1:0] b_line;
    logic [WIDTH-1:0]            a_tap;
    logic [WIDTH-1:0]            b_tap;

    // Operand lines parallel to the expected line, for the capture
    always_ff @(posedge clk_dut or posedge reset) begin
        if (reset) begin
            a_line <= '0;
            b_line <= '0;
        end else begin
            a_line[1] <= i_drive_delayed_a;
            b_line[1] <= i_drive_delayed_b;
            for (int unsigned k = 2; k <= MAX_LAT; k++) begin
                a_line[k] <= a_line[k-1];
                b_line[k] <= b_line[k-1];
            end
        end
    end

    always_comb begin
        a_tap = i_drive_delayed_a;
        b_tap = i_drive_delayed_b;
        if (tap_l != '0) begin
            a_tap = a_line[tap_l];
            b_tap = b_line[tap_l];
        end
    end

    // First mismatch only; clear re-arms
    always_ff @(posedge clk_dut or posedge reset) begin
        if (reset) begin
            o_fail_a     <= '0;
            o_fail_b     <= '0;
            o_fail_got   <= '0;
            o_fail_exp   <= '0;
            o_fail_valid <= 1'b0;
        end else if (i_clear) begin
            o_fail_a     <= '0;
            o_fail_b     <= '0;
            o_fail_got   <= '0;
            o_fail_exp   <= '0;
            o_fail_valid <= 1'b0;
        end else if (mismatch_c && !o_fail_valid) begin
            o_fail_a     <= a_tap;
            o_fail_b     <= b_tap;
            o_fail_got   <= i_dut_out;
            o_fail_exp   <= exp_tap;
            o_fail_valid <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_result_monitor.sv
// tb_result_monitor
//   Random-stimulus bench for result_monitor (OP=0). Emulates the stimulus driver
//   and a fixed-delay adder DUT from a history of driven vectors, and predicts the
//   monitor's counters from the alignment rule: at a compare edge the DUT output
//   must equal a+b of the vector driven D cycles earlier. A second instance with
//   4-bit counters exercises saturation.
module tb_result_monitor;

    localparam int unsigned W    = 32;
    localparam int unsigned MAXL = 15;
    localparam int unsigned OL   = 2;
    localparam int unsigned HN   = 1024;
    localparam logic [31:0] FLIP = 32'h0000_0100;

    logic        clk_dut = 1'b0;
    logic        reset;
    logic [31:0] d_in, a_in, b_in, out_in;
    logic        zi_in, clr_in;

    logic [3:0]  state, s_state;
    logic [31:0] tc, ec;
    logic [3:0]  s_tc, s_ec;
    logic        err, laterr, s_err, s_laterr;
`ifdef MON_CAPTURE_EN
    logic [31:0] fa, fb, fg, fe, s_fa, s_fb, s_fg, s_fe;
    logic        fv, s_fv;
`endif

    always #5 clk_dut = ~clk_dut;

    result_monitor #(.WIDTH(W), .OP(0), .MAX_LAT(MAXL), .OPND_LAT(OL), .CNT_W(32)) u_dut (
        .clk_dut(clk_dut), .reset(reset), .i_dut_delay(d_in),
        .i_drive_delayed_a(a_in), .i_drive_delayed_b(b_in), .i_zero_inject(zi_in),
        .i_dut_out(out_in), .i_clear(clr_in), .o_state(state), .o_test_count(tc),
        .o_err_count(ec), .o_error(err), .o_lat_err(laterr)
`ifdef MON_CAPTURE_EN
        , .o_fail_a(fa), .o_fail_b(fb), .o_fail_got(fg), .o_fail_exp(fe), .o_fail_valid(fv)
`endif
    );

    result_monitor #(.WIDTH(W), .OP(0), .MAX_LAT(MAXL), .OPND_LAT(OL), .CNT_W(4)) u_sat (
        .clk_dut(clk_dut), .reset(reset), .i_dut_delay(d_in),
        .i_drive_delayed_a(a_in), .i_drive_delayed_b(b_in), .i_zero_inject(zi_in),
        .i_dut_out(out_in), .i_clear(clr_in), .o_state(s_state), .o_test_count(s_tc),
        .o_err_count(s_ec), .o_error(s_err), .o_lat_err(s_laterr)
`ifdef MON_CAPTURE_EN
        , .o_fail_a(s_fa), .o_fail_b(s_fb), .o_fail_got(s_fg), .o_fail_exp(s_fe), .o_fail_valid(s_fv)
`endif
    );

    // Driven-vector history (ring)
    logic [31:0] h_a   [HN];
    logic [31:0] h_b   [HN];
    bit          h_zi  [HN];
    bit          h_flip[HN];
    int          n;
    int          d_true;
    bit          in_reset;

    // Reference model state: 0 idle, 1 fill, 2 check, 3 laterr
    int          m_phase, m_left, m_dlat;
    int unsigned m_tests, m_errs;
    bit          m_error;
    bit          m_fv;
    logic [31:0] m_fa, m_fb, m_fg, m_fe;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic int hix(input int k);
        return k % HN;
    endfunction

    function automatic int unsigned sat4(input int unsigned v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_left = 0; m_dlat = 0;
        m_tests = 0; m_errs = 0; m_error = 0;
        m_fv = 0; m_fa = 0; m_fb = 0; m_fg = 0; m_fe = 0;
    endtask

    // Apply one cycle of inputs, advance the model across the coming edge, sample after it
    task automatic step(input logic [31:0] a, input logic [31:0] b, input bit zi,
                        input bit fl, input bit clr);
        int          src, ms;
        logic [31:0] exp_v;
        n++;
        h_a[hix(n)] = a; h_b[hix(n)] = b; h_zi[hix(n)] = zi; h_flip[hix(n)] = fl;
        a_in  = h_a[hix(n - OL)];
        b_in  = h_b[hix(n - OL)];
        zi_in = h_zi[hix(n - OL)];
        src   = hix(n - d_true);
        out_in = (h_zi[src] ? 32'h0 : h_a[src] + h_b[src]) ^ (h_flip[src] ? FLIP : 32'h0);
        clr_in = clr;
        if (!in_reset) begin
            case (m_phase)
                0: if (d_in != 32'hFFFF_FFFF) begin
                       if (d_in < OL || d_in > OL + MAXL) m_phase = 3;
                       else begin
                           m_phase = 1;
                           m_dlat  = int'(d_in);
                           m_left  = m_dlat - int'(OL) + 1;
                       end
                   end
                1: begin
                       m_left--;
                       if (m_left == 0) m_phase = 2;
                   end
                2: begin
                       ms    = hix(n - m_dlat);
                       exp_v = h_a[ms] + h_b[ms];
                       if (!h_zi[ms]) begin
                           m_tests++;
                           if (out_in != exp_v) begin
                               m_errs++;
                               m_error = 1;
                               if (!m_fv) begin
                                   m_fv = 1; m_fa = h_a[ms]; m_fb = h_b[ms];
                                   m_fg = out_in; m_fe = exp_v;
                               end
                           end
                       end
                   end
                default: ;
            endcase
            if (clr) begin
                m_tests = 0; m_errs = 0; m_error = 0;
                m_fv = 0; m_fa = 0; m_fb = 0; m_fg = 0; m_fe = 0;
            end
        end
        @(posedge clk_dut);
        #1;
    endtask

    task automatic rand_steps(input int cnt);
        for (int i = 0; i < cnt; i++) step($urandom, $urandom, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        in_reset = 1'b1;
        model_reset();
        for (int i = 0; i < cycles; i++) step($urandom, $urandom, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        in_reset = 1'b0;
    endtask

    task automatic check_all(input string tag);
        logic [3:0] oh;
        oh = 4'b0001 << m_phase;
        check({tag, ".state"},    64'(state),    64'(oh));
        check({tag, ".tests"},    64'(tc),       64'(m_tests));
        check({tag, ".errs"},     64'(ec),       64'(m_errs));
        check({tag, ".error"},    64'(err),      64'(m_error));
        check({tag, ".laterr"},   64'(laterr),   64'(m_phase == 3));
        check({tag, ".s_tests"},  64'(s_tc),     64'(sat4(m_tests)));
        check({tag, ".s_errs"},   64'(s_ec),     64'(sat4(m_errs)));
`ifdef MON_CAPTURE_EN
        check({tag, ".fvalid"},   64'(fv),       64'(m_fv));
        check({tag, ".fa"},       64'(fa),       64'(m_fa));
        check({tag, ".fb"},       64'(fb),       64'(m_fb));
        check({tag, ".fgot"},     64'(fg),       64'(m_fg));
        check({tag, ".fexp"},     64'(fe),       64'(m_fe));
`endif
    endtask

    initial begin
        logic [31:0] b5;
        for (int i = 0; i < int'(HN); i++) begin
            h_a[i] = 0; h_b[i] = 0; h_zi[i] = 0; h_flip[i] = 0;
        end
        n = 100; d_true = 4; in_reset = 0;
        reset = 1'b1; d_in = 32'hFFFF_FFFF;
        a_in = 0; b_in = 0; zi_in = 0; out_in = 0; clr_in = 0;
        model_reset();
        #2;
        check_all("rst_async");
        do_reset(3);
        check_all("rst");

        // Unmeasured delay keeps the monitor idle
        rand_steps(5);
        check("idle_wait.state", 64'(state), 64'h1);

        // D=4 (L=2): three FILL cycles then CHECK
        d_in = 4;
        rand_steps(1);
        check("d4.fill", 64'(state), 64'h2);
        rand_steps(2);
        check("d4.fill_last", 64'(state), 64'h2);
        rand_steps(1);
        check("d4.check", 64'(state), 64'h4);
        rand_steps(20);
        check_all("d4.warm");

        // 1000 random vectors after a clear
        step($urandom, $urandom, 1'b0, 1'b0, 1'b1);
        rand_steps(1000);
        check_all("d4.rand1000");
        check("d4.tc1000", 64'(tc), 64'd1000);
        check("d4.ec0", 64'(ec), 64'd0);

        // Single bit-flip on the vector with a == 5
        b5 = $urandom;
        step(32'h5, b5, 1'b0, 1'b1, 1'b0);
        rand_steps(10);
        check_all("flip");
        check("flip.ec1", 64'(ec), 64'd1);
        check("flip.error", 64'(err), 64'd1);
`ifdef MON_CAPTURE_EN
        check("flip.fa5", 64'(fa), 64'h5);
        check("flip.fexp", 64'(fe), 64'(32'h5 + b5));
        check("flip.fgot", 64'(fg), 64'(fe ^ FLIP));
`endif

        // Zero-inject: raw 3,4 while the DUT sees 0,0 -> skipped compare
        step($urandom, $urandom, 1'b0, 1'b0, 1'b1);
        step(32'd3, 32'd4, 1'b1, 1'b0, 1'b0);
        rand_steps(9);
        check_all("zinj");
        check("zinj.tc9", 64'(tc), 64'd9);
        check("zinj.ec0", 64'(ec), 64'd0);

        // Reported delay changes after latch are ignored
        d_in = 9;
        rand_steps(20);
        check_all("dchange");
        d_in = 4;

        // Saturation on the 4-bit instance, then clear colliding with a mismatch
        for (int i = 0; i < 24; i++) step($urandom, $urandom, 1'b0, 1'b1, 1'b0);
        check("sat.s_ec", 64'(s_ec), 64'hF);
        check("sat.s_tc", 64'(s_tc), 64'hF);
        check_all("sat");
        step($urandom, $urandom, 1'b0, 1'b1, 1'b1);
        check("clrwin.ec", 64'(ec), 64'd0);
        check("clrwin.tc", 64'(tc), 64'd0);
        check("clrwin.error", 64'(err), 64'd0);
        check("clrwin.s_ec", 64'(s_ec), 64'd0);
        for (int i = 0; i < 6; i++) step($urandom, $urandom, 1'b0, 1'b1, 1'b0);
        check_all("post_clr");

        // Reset mid-CHECK, restart with D still valid
        reset = 1'b1;
        in_reset = 1'b1;
        model_reset();
        #2;
        check_all("midrst_async");
        do_reset(2);
        rand_steps(1);
        check("midrst.fill", 64'(state), 64'h2);
        rand_steps(3);
        check("midrst.check", 64'(state), 64'h4);
        rand_steps(30);
        check_all("midrst.run");

        // Out-of-range delays
        d_in = 1;
        do_reset(2);
        rand_steps(1);
        check("d1.laterr", 64'(laterr), 64'd1);
        rand_steps(5);
        check_all("d1");
        d_in = 18;
        do_reset(2);
        rand_steps(6);
        check_all("d18");
        check("d18.state", 64'(state), 64'h8);

        // D=17 (L=15): 16 FILL cycles
        d_in = 17; d_true = 17;
        do_reset(2);
        rand_steps(16);
        check("d17.fill16", 64'(state), 64'h2);
        rand_steps(1);
        check("d17.check", 64'(state), 64'h4);
        rand_steps(40);
        check_all("d17.run");

        // D=2 (L=0): combinational tap path, one flip
        d_in = 2; d_true = 2;
        do_reset(2);
        rand_steps(5);
        step($urandom, $urandom, 1'b0, 1'b1, 1'b0);
        rand_steps(20);
        check_all("d2.run");
        check("d2.ec1", 64'(ec), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
